delay_down_counter: RTL and testbench

Loadable down-counter that times a programmed delay and signals expiry with a borrow/underflow pulse. It is the countdown counterpart to the free-running up-counter with overflow flag used in the delay-line datapath. A producer hands it a delay value over a valid/ready handshake. It counts down on enabled cycles and pulses underflow when the count passes zero. Optional auto-reload turns it into a periodic tick generator.

---
 rtl/delay_down_counter_pkg.sv | 16 +
 rtl/delay_down_counter.sv | 72 +++++++
 tb/tb_delay_down_counter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/delay_down_counter_pkg.sv
// Types and constants for the delay-line counters.
package delay_down_counter_pkg;

    // Default counter width, the same width the delay-line up-counter uses.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Count value that marks the terminal cycle.
    localparam int unsigned CNT_ZERO = 0;

    // The counter is either waiting for a load or timing a delay.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage : delay_down_counter_pkg

// File: rtl/delay_down_counter.sv
// Loadable down-counter that times a programmed delay and pulses underflow on expiry.
// A delay of N takes N+1 enabled cycles; with AUTO_RELOAD it becomes a periodic tick.
module delay_down_counter
    import delay_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             underflow
);

    state_t           state;
    logic [WIDTH-1:0] reload_value;
    logic             at_zero;

    // Terminal count is seen at zero, so the decrement never wraps.
    assign at_zero = (cnt_out == WIDTH'(CNT_ZERO));

    // State, count, reload value and underflow pulse; abort beats load and terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt_out      <= WIDTH'(CNT_ZERO);
            reload_value <= WIDTH'(CNT_ZERO);
            underflow    <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                cnt_out <= WIDTH'(CNT_ZERO);
            end else begin
                case (state)
                    IDLE: begin
                        if (load_valid) begin
                            cnt_out      <= load_value;
                            reload_value <= load_value;
                            state        <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (en) begin
                            if (at_zero) begin
                                underflow <= 1'b1;
                                if (AUTO_RELOAD) begin
                                    cnt_out <= reload_value;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                cnt_out <= cnt_out - WIDTH'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Status flags are plain decodes of the registered state.
    assign busy       = (state == COUNT);
    assign load_ready = (state == IDLE);

endmodule : delay_down_counter

// File: tb/tb_delay_down_counter.sv
// Bench for delay_down_counter: one-shot and auto-reload instances, scoreboard-checked.
module tb_delay_down_counter;

    localparam int unsigned W = 4;

    typedef struct {
        int         dut;
        logic [W-1:0] cnt;
        logic       busy;
        logic       uf;
        logic       rdy;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         lv_i  [2];
    logic [W-1:0] val_i [2];
    logic         en_i  [2];
    logic         ab_i  [2];
    logic         rdy_o [2];
    logic [W-1:0] cnt_o [2];
    logic         busy_o[2];
    logic         uf_o  [2];

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;
    event  sample_ev;

    delay_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_os (
        .clk(clk), .rst(rst),
        .load_valid(lv_i[0]), .load_ready(rdy_o[0]), .load_value(val_i[0]),
        .en(en_i[0]), .abort(ab_i[0]),
        .cnt_out(cnt_o[0]), .busy(busy_o[0]), .underflow(uf_o[0])
    );

    delay_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rst(rst),
        .load_valid(lv_i[1]), .load_ready(rdy_o[1]), .load_value(val_i[1]),
        .en(en_i[1]), .abort(ab_i[1]),
        .cnt_out(cnt_o[1]), .busy(busy_o[1]), .underflow(uf_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int d, input logic [W-1:0] c, input logic b, input logic u,
                        input logic r, input string nm);
        exp_t e;
        e.dut = d; e.cnt = c; e.busy = b; e.uf = u; e.rdy = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Drive inputs for the next edge of dut d, then queue the outputs expected after it.
    task automatic step(input int d, input logic lv, input logic [W-1:0] v, input logic e,
                        input logic ab, input logic [W-1:0] ec, input logic eb,
                        input logic eu, input logic er, input string nm);
        lv_i[d] = lv; val_i[d] = v; en_i[d] = e; ab_i[d] = ab;
        lv_i[1-d] = 1'b0; en_i[1-d] = 1'b0; ab_i[1-d] = 1'b0;
        @(posedge clk);
        #1;
        push(d, ec, eb, eu, er, nm);
    endtask

    // Monitor: compare one queued expectation per sample point.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (cnt_o[e.dut] !== e.cnt || busy_o[e.dut] !== e.busy ||
                    uf_o[e.dut] !== e.uf || rdy_o[e.dut] !== e.rdy) begin
                    errors++;
                    $display("FAIL %s dut%0d: cnt=%0d busy=%b uf=%b rdy=%b, expected cnt=%0d busy=%b uf=%b rdy=%b",
                             nm, e.dut, cnt_o[e.dut], busy_o[e.dut], uf_o[e.dut], rdy_o[e.dut],
                             e.cnt, e.busy, e.uf, e.rdy);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lv_i[i] = 1'b0; val_i[i] = '0; en_i[i] = 1'b0; ab_i[i] = 1'b0;
        end
        #1;
        push(0, 4'd0, 1'b0, 1'b0, 1'b1, "reset_os");
        @(negedge clk);
        #1;
        push(1, 4'd0, 1'b0, 1'b0, 1'b1, "reset_ar");
        @(negedge clk);
        #1;
        rst = 1'b0;

        // N=3: 3,2,1,0 then underflow with return to IDLE.
        step(0, 1, 4'd3, 1, 0, 4'd3, 1, 0, 0, "n3_load");
        step(0, 0, 4'd0, 1, 0, 4'd2, 1, 0, 0, "n3_cnt2");
        step(0, 0, 4'd0, 1, 0, 4'd1, 1, 0, 0, "n3_cnt1");
        step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, "n3_cnt0");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "n3_underflow");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "n3_after");

        // N=0: underflow two cycles after accept.
        step(0, 1, 4'd0, 1, 0, 4'd0, 1, 0, 0, "n0_load");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "n0_underflow");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "n0_after");

        // N=15: underflow 17 cycles after accept.
        step(0, 1, 4'd15, 1, 0, 4'd15, 1, 0, 0, "n15_load");
        for (int k = 14; k >= 0; k--)
            step(0, 0, 4'd0, 1, 0, W'(k), 1, 0, 0, "n15_cnt");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "n15_underflow");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "n15_after");

        // N=5 with three en=0 cycles: underflow at t+10.
        step(0, 1, 4'd5, 1, 0, 4'd5, 1, 0, 0, "en_load");
        step(0, 0, 4'd0, 1, 0, 4'd4, 1, 0, 0, "en_cnt4");
        step(0, 0, 4'd0, 1, 0, 4'd3, 1, 0, 0, "en_cnt3");
        step(0, 0, 4'd0, 0, 0, 4'd3, 1, 0, 0, "en_hold1");
        step(0, 0, 4'd0, 0, 0, 4'd3, 1, 0, 0, "en_hold2");
        step(0, 0, 4'd0, 0, 0, 4'd3, 1, 0, 0, "en_hold3");
        step(0, 0, 4'd0, 1, 0, 4'd2, 1, 0, 0, "en_cnt2");
        step(0, 0, 4'd0, 1, 0, 4'd1, 1, 0, 0, "en_cnt1");
        step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, "en_cnt0");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 1, "en_underflow");

        // N=4 with abort on the terminal cycle: no underflow.
        step(0, 1, 4'd4, 1, 0, 4'd4, 1, 0, 0, "ab_load");
        step(0, 0, 4'd0, 1, 0, 4'd3, 1, 0, 0, "ab_cnt3");
        step(0, 0, 4'd0, 1, 0, 4'd2, 1, 0, 0, "ab_cnt2");
        step(0, 0, 4'd0, 1, 0, 4'd1, 1, 0, 0, "ab_cnt1");
        step(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, 0, "ab_cnt0");
        step(0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 1, "ab_terminal");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "ab_no_uf");
        // Abort with a load offer in IDLE: load rejected.
        step(0, 1, 4'd7, 1, 1, 4'd0, 0, 0, 1, "ab_load_reject");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "ab_still_idle");
        // Abort mid-count.
        step(0, 1, 4'd6, 1, 0, 4'd6, 1, 0, 0, "ab_mid_load");
        step(0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 1, "ab_mid");

        // Auto-reload N=2: pattern 1,0,2(uf) x4; loads while busy ignored.
        step(1, 1, 4'd2, 1, 0, 4'd2, 1, 0, 0, "ar_load");
        for (int p = 0; p < 4; p++) begin
            step(1, 1, 4'd9, 1, 0, 4'd1, 1, 0, 0, "ar_cnt1");
            step(1, 1, 4'd9, 1, 0, 4'd0, 1, 0, 0, "ar_cnt0");
            step(1, 1, 4'd9, 1, 0, 4'd2, 1, 1, 0, "ar_reload_uf");
        end
        step(1, 0, 4'd0, 0, 0, 4'd2, 1, 0, 0, "ar_frozen");
        step(1, 0, 4'd0, 1, 1, 4'd0, 0, 0, 1, "ar_abort");
        // Auto-reload N=0: underflow on every enabled cycle.
        step(1, 1, 4'd0, 1, 0, 4'd0, 1, 0, 0, "ar0_load");
        step(1, 0, 4'd0, 1, 0, 4'd0, 1, 1, 0, "ar0_uf1");
        step(1, 0, 4'd0, 1, 0, 4'd0, 1, 1, 0, "ar0_uf2");
        step(1, 0, 4'd0, 1, 1, 4'd0, 0, 0, 1, "ar0_abort");

        // Asynchronous reset mid-count at cnt_out=2.
        step(0, 1, 4'd4, 1, 0, 4'd4, 1, 0, 0, "rst_load");
        step(0, 0, 4'd0, 1, 0, 4'd3, 1, 0, 0, "rst_cnt3");
        step(0, 0, 4'd0, 1, 0, 4'd2, 1, 0, 0, "rst_cnt2");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        push(0, 4'd0, 1'b0, 1'b0, 1'b1, "rst_async");
        -> sample_ev;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "rst_after1");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "rst_after2");
        step(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 1, "rst_after3");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_delay_down_counter
